// File: rtl/alu_cmd_ctrl.sv
// Command-frame decoder that drives the ALU and returns each result as one tx byte.
// Optional macro ALU_WAIT_TIMEOUT_EN bounds the result wait and returns ERR_CODE on expiry.
module alu_cmd_ctrl #(
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] CMD_OP         = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_REUSE      = 8'hDD,
  parameter logic [DATA_WIDTH-1:0] ERR_CODE       = 8'hEE,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_fun,
  output logic                  alu_en,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_out_valid,
  output logic                  busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_A    = 3'd1;
  localparam logic [2:0] GET_B    = 3'd2;
  localparam logic [2:0] GET_FUN  = 3'd3;
  localparam logic [2:0] ISSUE    = 3'd4;
  localparam logic [2:0] WAIT_RES = 3'd5;
  localparam logic [2:0] SEND_RES = 3'd6;

  logic [2:0]            state_reg;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [3:0]            fun_reg;
  logic [DATA_WIDTH-1:0] tx_data_reg;
  logic                  tx_valid_reg;

`ifdef ALU_WAIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_reg;
  // Last WAIT_RES cycle before expiry; a result in this same cycle still wins.
  logic             wait_last;
  assign wait_last = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_CODE, 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      fun_reg      <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
`ifdef ALU_WAIT_TIMEOUT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_OP) begin
              state_reg <= GET_A;
            end else if (rx_data == CMD_REUSE) begin
              state_reg <= GET_FUN;
            end
          end
        end
        GET_A: begin
          if (rx_valid) begin
            a_reg     <= rx_data;
            state_reg <= GET_B;
          end
        end
        GET_B: begin
          if (rx_valid) begin
            b_reg     <= rx_data;
            state_reg <= GET_FUN;
          end
        end
        GET_FUN: begin
          if (rx_valid) begin
            fun_reg   <= rx_data[3:0];
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          state_reg <= WAIT_RES;
`ifdef ALU_WAIT_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
        end
        WAIT_RES: begin
`ifdef ALU_WAIT_TIMEOUT_EN
          wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
`endif
          if (alu_out_valid) begin
            tx_data_reg  <= alu_out;
            tx_valid_reg <= 1'b1;
            state_reg    <= SEND_RES;
`ifdef ALU_WAIT_TIMEOUT_EN
          end else if (wait_last) begin
            tx_data_reg  <= ERR_CODE;
            tx_valid_reg <= 1'b1;
            state_reg    <= SEND_RES;
`endif
          end
        end
        SEND_RES: begin
          if (tx_ready) begin
            tx_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign alu_a    = a_reg;
  assign alu_b    = b_reg;
  assign alu_fun  = fun_reg;
  assign alu_en   = (state_reg == ISSUE);
  assign busy     = (state_reg == ISSUE) || (state_reg == WAIT_RES) || (state_reg == SEND_RES);
  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: frame-level reference model plus a small ALU responder.
// Define ALU_WAIT_TIMEOUT_EN here as well as in the RTL to exercise the timeout cases.
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;

  localparam logic [7:0] CC  = 8'hCC;
  localparam logic [7:0] DD  = 8'hDD;
  localparam logic [7:0] ERR = 8'hEE;
  localparam int         TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_fun;
  logic       alu_en;
  logic [7:0] alu_out = 8'h00;
  logic       alu_out_valid = 1'b0;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  always #5 clk = ~clk;

  alu_cmd_ctrl dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .busy(busy)
  );

  // ALU responder: result valid alu_delay+1 cycles after the enable, or never if silent.
  int         alu_delay  = 0;
  bit         alu_silent = 0;
  int         dly_cnt    = 0;
  logic [7:0] alu_res    = 8'h00;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      default: return a + {4'b0000, f};
    endcase
  endfunction

  always @(posedge clk) begin
    alu_out_valid <= 1'b0;
    if (dly_cnt > 0) begin
      dly_cnt <= dly_cnt - 1;
      if (dly_cnt == 1) begin
        alu_out_valid <= 1'b1;
        alu_out       <= alu_res;
      end
    end
    if (alu_en === 1'b1 && !alu_silent) begin
      if (alu_delay == 0) begin
        alu_out_valid <= 1'b1;
        alu_out       <= alu_f(alu_a, alu_b, alu_fun);
      end else begin
        dly_cnt <= alu_delay;
        alu_res <= alu_f(alu_a, alu_b, alu_fun);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames as byte lists, then issue / wait / send as a transaction lifecycle.
  logic [7:0] frame[$];
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m_txd = 8'h00;
  logic [3:0] m_fun = 4'h0;
  bit         m_issue = 0, m_wait = 0, m_tx = 0;
  int         m_wcnt = 0;

  task automatic model_step();
    if (rst) begin
      m_a = 8'h00; m_b = 8'h00; m_fun = 4'h0; m_txd = 8'h00;
      m_issue = 0; m_wait = 0; m_tx = 0; m_wcnt = 0;
      frame.delete();
    end else if (m_tx) begin
      if (tx_ready) m_tx = 0;
    end else if (m_wait) begin
      m_wcnt++;
      if (alu_out_valid) begin
        m_tx = 1; m_txd = alu_out; m_wait = 0;
`ifdef ALU_WAIT_TIMEOUT_EN
      end else if (m_wcnt == TMO) begin
        m_tx = 1; m_txd = ERR; m_wait = 0;
`endif
      end
    end else if (m_issue) begin
      m_issue = 0; m_wait = 1; m_wcnt = 0;
    end else if (rx_valid) begin
      if (frame.size() == 0) begin
        if (rx_data == CC || rx_data == DD) frame.push_back(rx_data);
      end else begin
        frame.push_back(rx_data);
        if (frame[0] == CC && frame.size() == 4) begin
          m_a = frame[1]; m_b = frame[2]; m_fun = frame[3][3:0];
          m_issue = 1; frame.delete();
        end else if (frame[0] == DD && frame.size() == 2) begin
          m_fun = frame[1][3:0];
          m_issue = 1; frame.delete();
        end
      end
    end
  endtask

  // Compare outputs mid-cycle, then advance the model with the inputs the DUT samples next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("busy", busy, m_issue | m_wait | m_tx);
        chk("alu_en", alu_en, m_issue);
        chk("tx_valid", tx_valid, m_tx);
        if (m_tx) chk("tx_data", tx_data, m_txd);
        if (frame.size() == 0) begin
          chk("alu_a", alu_a, m_a);
          chk("alu_b", alu_b, m_b);
          chk("alu_fun", alu_fun, m_fun);
        end
      end
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Wait for the enable, pin operands, then measure enable-to-tx_valid latency and result byte.
  task automatic run_op(input logic [7:0] ea, input logic [7:0] eb, input logic [3:0] ef,
                        input logic [7:0] eres, input int elat);
    int n;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (alu_en === 1'b1) break;
    end
    chk("en_seen", alu_en, 1'b1);
    chk("en_a", alu_a, ea);
    chk("en_b", alu_b, eb);
    chk("en_fun", alu_fun, ef);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (tx_valid === 1'b1) break;
    end
    chk("tx_latency", n, elat);
    chk("res_byte", tx_data, eres);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_b", alu_b, 8'h00);
    chk("rst_alu_fun", alu_fun, 4'h0);
    chk("rst_alu_en", alu_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    chk_on = 1;

    send(CC); send(8'h05); send(8'h03); send(8'h00);
    run_op(8'h05, 8'h03, 4'h0, 8'h08, 2);
    tick();

    send(DD); send(8'h01);
    run_op(8'h05, 8'h03, 4'h1, 8'h02, 2);
    tick();

    tx_ready = 1'b0;
    send(DD); send(8'h02);
    run_op(8'h05, 8'h03, 4'h2, 8'h01, 2);
    tick();
    send(8'h11); send(8'h22);
    repeat (3) tick();
    @(negedge clk);
    chk("bp_tx_valid", tx_valid, 1'b1);
    chk("bp_tx_data", tx_data, 8'h01);
    chk("bp_busy", busy, 1'b1);
    tick();
    tx_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_done_busy", busy, 1'b0);
    chk("bp_done_valid", tx_valid, 1'b0);
    tick();
    send(CC); send(8'h10); send(8'h20); send(8'h04);
    run_op(8'h10, 8'h20, 4'h4, 8'h30, 2);
    tick();

    send(8'h11); send(CC); send(8'h0A); send(8'h02); send(8'hF3);
    run_op(8'h0A, 8'h02, 4'h3, 8'h0A, 2);
    tick();

    alu_delay = 3;
    send(DD); send(8'h00);
    @(negedge clk);
    chk("wr_en", alu_en, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("wr_rst_valid", tx_valid, 1'b0);
    chk("wr_rst_busy", busy, 1'b0);
    chk("wr_rst_a", alu_a, 8'h00);
    repeat (6) tick();
    @(negedge clk);
    chk("late_valid_ignored", tx_valid, 1'b0);
    tick();

    alu_delay = 0;
    tx_ready  = 1'b0;
    send(DD); send(8'h00);
    run_op(8'h00, 8'h00, 4'h0, 8'h00, 2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("sr_rst_valid", tx_valid, 1'b0);
    chk("sr_rst_busy", busy, 1'b0);
    tick();

    send(CC); send(8'h07); send(8'h05); send(8'h00);
    run_op(8'h07, 8'h05, 4'h0, 8'h0C, 2);
    tick();

`ifdef ALU_WAIT_TIMEOUT_EN
    alu_silent = 1;
    send(DD); send(8'h01);
    run_op(8'h07, 8'h05, 4'h1, ERR, TMO + 1);
    tick();
    alu_silent = 0;
    alu_delay  = TMO - 1;
    send(DD); send(8'h00);
    run_op(8'h07, 8'h05, 4'h0, 8'h0C, TMO + 1);
    tick();
    alu_delay = 0;
`endif

    for (int c = 0; c < 4000; c++) begin
      int r;
      rst       = ($urandom_range(0, 299) == 0);
      rx_valid  = $urandom_range(0, 1) == 1;
      r         = $urandom_range(0, 9);
      rx_data   = (r < 3) ? CC : (r < 5) ? DD : 8'($urandom);
      tx_ready  = $urandom_range(0, 3) != 0;
      alu_delay = $urandom_range(0, 3);
`ifdef ALU_WAIT_TIMEOUT_EN
      alu_silent = $urandom_range(0, 5) == 0;
`endif
      tick();
    end
    rst        = 1'b0;
    rx_valid   = 1'b0;
    tx_ready   = 1'b1;
    alu_silent = 0;
    repeat (40) tick();
    chk_on = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
